fsm_seq_decoder: RTL and testbench
==================================

// Module: fsm_seq_decoder
// PURPOSE
//  Receive-side observer for the 3-bit state-code stream produced by our
//  a-driven sequence FSM (legal codes 2,6,4,7,1).
//  Validates every code-to-code transition and recovers the input bit 'a'
//  from the branching transitions.
//  Reports sync/lock status and counts protocol errors.
//  Sits downstream of the FSM output bus, sampled once per code_valid strobe.
// PARAMETERS
//  LOCK_CNT  3  consecutive legal transitions required to assert locked (>=1)
//  BITS      8  width of recovered-bit shift register a_shift
//  ERR_W     8  width of saturating error counter err_cnt
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  code_valid in   1      code is sampled on this cycle
//  code       in   3      observed FSM state/output code
//  err_clr    in   1      synchronous clear of err_cnt
//  a_valid    out  1      1-cycle pulse: a_out holds a recovered bit
//  a_out      out  1      recovered 'a' value
//  a_shift    out  BITS   recovered bits; newest in bit0, shifts left
//  locked     out  1      LOCK_CNT consecutive legal transitions seen
//  err_pulse  out  1      1-cycle pulse on illegal code or transition
//  err_cnt    out  ERR_W  saturating error count
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, prev=0, good_cnt=0. Async assert, sync-safe release.
//  All outputs registered. Response appears the cycle after the sampling edge (latency 1).
//  code_valid=0: no state change; a_valid=0 and err_pulse=0 that cycle.
//  Legal transitions (prev->code):
//    2->4, 6->7, 1->6, 4->1 (a=1), 4->6 (a=0), 7->4 (a=1), 7->2 (a=0).
//  States:
//   IDLE (no reference code):
//     legal code -> prev=code, go TRACK, no check, no pulse.
//     code in {0,3,5} -> err_pulse, stay IDLE.
//   TRACK:
//     code in {0,3,5} -> err_pulse, good_cnt=0, locked=0, go IDLE.
//     legal transition -> prev=code; good_cnt+=1, saturating at LOCK_CNT;
//       locked=1 once good_cnt reaches LOCK_CNT.
//       If prev is 4 or 7: a_valid=1, a_out=decoded a,
//       a_shift={a_shift[BITS-2:0],a}.
//     legal code, illegal transition (incl. repeated code and source reset
//       to 2 from a state other than 7) -> err_pulse, good_cnt=0, locked=0,
//       prev=code (resync), stay TRACK, no a_valid.
//  err_cnt: +1 per err_pulse; saturates at all-ones (no wrap).
//    err_clr alone -> 0.
//    err_clr together with an error -> 1.
//  locked stays 1 through legal transitions. It drops only on an error or reset.
//  Reset mid-stream: everything returns to reset values; the next code re-enters via IDLE.
// TESTING
//  1 Reset, then codes 2,4,1,6,7,4,6,7,2 (code_valid=1 each cycle):
//    a_valid pulses 4x with a_out=1,1,0,0; a_shift[3:0]=4'b1100; err_cnt=0.
//  2 Same stream, lock timing: locked=0 through code 1; locked=1 the cycle
//    after code 6 is sampled; stays 1 to the end.
//  3 Locked stream 2,4,1 then code 4 (1->4 illegal):
//    err_pulse=1 for one cycle, locked=0, err_cnt=1, no a_valid;
//    then 1 is legal from 4 -> a_valid with a_out=1.
//  4 Code 5 while in TRACK: err_pulse, state IDLE.
//    The next code 7 produces no check; the following 2 gives a_valid with a_out=0.
//  5 Force 2^ERR_W+3 errors: err_cnt holds 8'hFF.
//    err_clr with a simultaneous error -> err_cnt=1; err_clr alone -> 0.
//  6 Assert reset mid-stream with code_valid gaps:
//    all outputs go 0 immediately; gaps produce no state change or pulses.

Source files
------------

// File: rtl/fsm_seq_decoder_if.sv
// Code-stream bus between the sequence FSM observer and its consumer.
// The master drives the sampled code stream; the slave (decoder) returns the status.
interface fsm_seq_decoder_if #(
    parameter int unsigned BITS  = 8,
    parameter int unsigned ERR_W = 8
);
    logic             code_valid;
    logic [2:0]       code;
    logic             err_clr;
    logic             a_valid;
    logic             a_out;
    logic [BITS-1:0]  a_shift;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output code_valid, code, err_clr,
        input  a_valid, a_out, a_shift, locked, err_pulse, err_cnt
    );

    modport slave (
        input  code_valid, code, err_clr,
        output a_valid, a_out, a_shift, locked, err_pulse, err_cnt
    );
endinterface

// File: rtl/fsm_seq_decoder.sv
// Observer for the 3-bit state-code stream of the a-driven sequence FSM:
// checks every transition, recovers 'a' from branch points, tracks lock and errors.
module fsm_seq_decoder #(
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned BITS     = 8,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    fsm_seq_decoder_if.slave bus
);
    localparam int unsigned CNT_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

    localparam logic [2:0] C1 = 3'd1;
    localparam logic [2:0] C2 = 3'd2;
    localparam logic [2:0] C4 = 3'd4;
    localparam logic [2:0] C6 = 3'd6;
    localparam logic [2:0] C7 = 3'd7;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_e;

    state_e           state_q;
    logic [2:0]       prev_q;
    logic [CNT_W-1:0] good_q;
    logic             locked_q;
    logic             a_valid_q;
    logic             a_out_q;
    logic [BITS-1:0]  a_shift_q;
    logic             err_pulse_q;
    logic [ERR_W-1:0] err_cnt_q;

    logic             code_legal;
    logic             trans_ok;
    logic             has_a;
    logic             a_bit;
    logic             err_c;
    logic [CNT_W-1:0] good_d;

    // Transition table; branch sources 4 and 7 also yield the input bit.
    always_comb begin
        code_legal = 1'b0;
        trans_ok   = 1'b0;
        has_a      = 1'b0;
        a_bit      = 1'b0;
        case (bus.code)
            C1, C2, C4, C6, C7: code_legal = 1'b1;
            default:            code_legal = 1'b0;
        endcase
        case (prev_q)
            C2: trans_ok = (bus.code == C4);
            C6: trans_ok = (bus.code == C7);
            C1: trans_ok = (bus.code == C6);
            C4: begin
                has_a    = 1'b1;
                trans_ok = (bus.code == C1) || (bus.code == C6);
                a_bit    = (bus.code == C1);
            end
            C7: begin
                has_a    = 1'b1;
                trans_ok = (bus.code == C4) || (bus.code == C2);
                a_bit    = (bus.code == C4);
            end
            default: trans_ok = 1'b0;
        endcase
        err_c  = bus.code_valid && (!code_legal || ((state_q == TRACK) && !trans_ok));
        good_d = (good_q == CNT_W'(LOCK_CNT)) ? good_q : good_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            prev_q      <= 3'd0;
            good_q      <= '0;
            locked_q    <= 1'b0;
            a_valid_q   <= 1'b0;
            a_out_q     <= 1'b0;
            a_shift_q   <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            a_valid_q   <= 1'b0;
            err_pulse_q <= err_c;

            // A clear coinciding with an error leaves that error counted.
            if (err_c) begin
                if (bus.err_clr)
                    err_cnt_q <= ERR_W'(1);
                else if (err_cnt_q != '1)
                    err_cnt_q <= err_cnt_q + ERR_W'(1);
            end else if (bus.err_clr) begin
                err_cnt_q <= '0;
            end

            if (bus.code_valid) begin
                case (state_q)
                    IDLE: begin
                        if (code_legal) begin
                            prev_q  <= bus.code;
                            state_q <= TRACK;
                        end
                    end
                    TRACK: begin
                        if (!code_legal) begin
                            state_q  <= IDLE;
                            good_q   <= '0;
                            locked_q <= 1'b0;
                        end else if (trans_ok) begin
                            prev_q   <= bus.code;
                            good_q   <= good_d;
                            locked_q <= (good_d == CNT_W'(LOCK_CNT));
                            if (has_a) begin
                                a_valid_q <= 1'b1;
                                a_out_q   <= a_bit;
                                a_shift_q <= {a_shift_q[BITS-2:0], a_bit};
                            end
                        end else begin
                            // Legal code on an illegal edge: resync on it.
                            prev_q   <= bus.code;
                            good_q   <= '0;
                            locked_q <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.a_valid   = a_valid_q;
    assign bus.a_out     = a_out_q;
    assign bus.a_shift   = a_shift_q;
    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_fsm_seq_decoder.sv
// Table-driven bench for fsm_seq_decoder plus hand-written error-saturation sequence.
module tb_fsm_seq_decoder;
    logic clk;
    logic reset;

    fsm_seq_decoder_if #(.BITS(8), .ERR_W(8)) bus_if ();

    fsm_seq_decoder #(.LOCK_CNT(3), .BITS(8), .ERR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [2:0] code;
        logic       clr;
        logic       av;
        logic       a;
        logic       lk;
        logic       ep;
        logic [7:0] cnt;
        logic [7:0] sh;
    } vec_t;

    localparam int NV = 29;
    vec_t tv [NV];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic av, input logic a, input logic lk,
                           input logic ep, input logic [7:0] cnt, input logic [7:0] sh);
        chk("a_valid",   idx, 32'(bus_if.a_valid),   32'(av));
        chk("a_out",     idx, 32'(bus_if.a_out),     32'(a));
        chk("locked",    idx, 32'(bus_if.locked),    32'(lk));
        chk("err_pulse", idx, 32'(bus_if.err_pulse), 32'(ep));
        chk("err_cnt",   idx, 32'(bus_if.err_cnt),   32'(cnt));
        chk("a_shift",   idx, 32'(bus_if.a_shift),   32'(sh));
    endtask

    initial begin
        int exp_cnt;
        //         rst   vld   code  clr   av    a     lk    ep    cnt    sh
        // stream 2,4,1,6,7,4,6,7,2: four branch bits 1,1,0,0; lock after 6
        tv[0]  = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00};
        tv[1]  = '{1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00};
        tv[2]  = '{1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'h01};
        tv[3]  = '{1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'h01};
        tv[4]  = '{1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'h01};
        tv[5]  = '{1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'h03};
        tv[6]  = '{1'b0, 1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'h06};
        tv[7]  = '{1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'h06};
        tv[8]  = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'h0C};
        // locked 2,4,1 then illegal 1->4, resync, 4->1 recovers a=1
        tv[9]  = '{1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'h0C};
        tv[10] = '{1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'h19};
        tv[11] = '{1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 8'h19};
        tv[12] = '{1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'h33};
        // code 5 in TRACK -> IDLE; 7 re-enters unchecked; 7->2 gives a=0
        tv[13] = '{1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'h33};
        tv[14] = '{1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 8'h33};
        tv[15] = '{1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 8'h33};
        tv[16] = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 8'h66};
        // gap, repeated code, illegal codes in TRACK and IDLE, re-entry
        tv[17] = '{1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'h66};
        tv[18] = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 8'h66};
        tv[19] = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 8'h66};
        tv[20] = '{1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5, 8'h66};
        tv[21] = '{1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 8'h66};
        tv[22] = '{1'b0, 1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 8'hCC};
        // reset mid-stream, then gaps and re-entry through IDLE
        tv[23] = '{1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00};
        tv[24] = '{1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00};
        tv[25] = '{1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00};
        tv[26] = '{1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00};
        tv[27] = '{1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'h01};
        tv[28] = '{1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'h01};

        reset = 1'b1;
        bus_if.code_valid = 1'b0;
        bus_if.code       = 3'd0;
        bus_if.err_clr    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all(-1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            bus_if.code_valid = tv[i].vld;
            bus_if.code       = tv[i].code;
            bus_if.err_clr    = tv[i].clr;
            reset             = tv[i].rst;
            if (tv[i].rst) begin
                // Async reset must clear outputs before any clock edge.
                #1;
                chk_all(100 + i, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
            end
            @(posedge clk);
            #1;
            chk_all(i, tv[i].av, tv[i].a, tv[i].lk, tv[i].ep, tv[i].cnt, tv[i].sh);
        end

        // Error counter saturation: 2^8+3 illegal codes.
        exp_cnt = 0;
        for (int k = 0; k < 259; k++) begin
            @(negedge clk);
            bus_if.code_valid = 1'b1;
            bus_if.code       = 3'd5;
            bus_if.err_clr    = 1'b0;
            @(posedge clk);
            #1;
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            chk("sat_err_cnt",   200 + k, 32'(bus_if.err_cnt),   32'(exp_cnt));
            chk("sat_err_pulse", 200 + k, 32'(bus_if.err_pulse), 32'd1);
        end
        chk("sat_final", 500, 32'(bus_if.err_cnt), 32'hFF);

        // Clear together with an error keeps that one error.
        @(negedge clk);
        bus_if.code_valid = 1'b1;
        bus_if.code       = 3'd0;
        bus_if.err_clr    = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_with_err", 501, 32'(bus_if.err_cnt),   32'd1);
        chk("clr_err_ep",   501, 32'(bus_if.err_pulse), 32'd1);

        // Clear alone.
        @(negedge clk);
        bus_if.code_valid = 1'b0;
        bus_if.err_clr    = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_alone",    502, 32'(bus_if.err_cnt),   32'd0);
        chk("clr_alone_ep", 502, 32'(bus_if.err_pulse), 32'd0);

        @(negedge clk);
        bus_if.err_clr = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
